// File: rtl/adc_capture.sv
// Triggered ADC sample capture: arm, wait for an upward threshold crossing,
// store cap_len samples into a local buffer, then stream them out.
module adc_capture #(
  parameter int DW    = 14,
  parameter int DEPTH = 256,
  parameter int LW    = 9
) (
  input  logic          clk,
  input  logic          aresetn,
  input  logic [DW-1:0] s_data,
  input  logic          s_valid,
  input  logic          arm,
  input  logic          abort,
  input  logic [DW-1:0] thresh,
  input  logic [LW-1:0] cap_len,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_last,
  output logic [1:0]    state,
  output logic          done
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [LW-1:0] LEN_MAX = LW'(DEPTH);
  localparam logic [LW-1:0] ONE = LW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_CAPT  = 2'd2,
    S_READ  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] thr_q, thr_d;
  logic [LW-1:0] len_q, len_d;
  logic [DW-1:0] prev_q, prev_d;
  logic          pvld_q, pvld_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [LW-1:0] wcnt_q, wcnt_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [LW-1:0] rcnt_q, rcnt_d;
  logic [DW-1:0] mdat_q, mdat_d;
  logic          mvld_q, mvld_d;
  logic          mlst_q, mlst_d;
  logic          done_q, done_d;

  logic [DW-1:0] mem [DEPTH];
  logic          we;
  logic [AW-1:0] waddr;
  logic [LW-1:0] len_clamp;
  logic          xfer;
  logic          trig;

  assign len_clamp = (cap_len == '0 || cap_len > LEN_MAX)
                   ? LEN_MAX : cap_len;
  assign xfer = mvld_q && m_ready;
  assign trig = pvld_q && (prev_q < thr_q) && (s_data >= thr_q);

  always_comb begin
    state_d = state_q;
    thr_d   = thr_q;
    len_d   = len_q;
    prev_d  = prev_q;
    pvld_d  = pvld_q;
    wptr_d  = wptr_q;
    wcnt_d  = wcnt_q;
    rptr_d  = rptr_q;
    rcnt_d  = rcnt_q;
    mdat_d  = mdat_q;
    mvld_d  = mvld_q;
    mlst_d  = mlst_q;
    done_d  = 1'b0;
    we      = 1'b0;
    waddr   = wptr_q;
    if (abort) begin
      state_d = S_IDLE;
      mvld_d  = 1'b0;
      mlst_d  = 1'b0;
      pvld_d  = 1'b0;
      wptr_d  = '0;
      wcnt_d  = '0;
      rptr_d  = '0;
      rcnt_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (arm) begin
            thr_d   = thresh;
            len_d   = len_clamp;
            pvld_d  = 1'b0;
            wptr_d  = '0;
            wcnt_d  = '0;
            rptr_d  = '0;
            rcnt_d  = '0;
            state_d = S_ARMED;
          end
        end
        S_ARMED: begin
          if (s_valid) begin
            prev_d = s_data;
            pvld_d = 1'b1;
            if (trig) begin
              we      = 1'b1;
              waddr   = '0;
              wptr_d  = AW'(1);
              wcnt_d  = ONE;
              state_d = (len_q == ONE) ? S_READ : S_CAPT;
            end
          end
        end
        S_CAPT: begin
          if (s_valid) begin
            we     = 1'b1;
            waddr  = wptr_q;
            wptr_d = wptr_q + AW'(1);
            wcnt_d = wcnt_q + ONE;
            if (wcnt_q + ONE == len_q) begin
              state_d = S_READ;
            end
          end
        end
        S_READ: begin
          // Output register refills whenever empty or being drained.
          if (xfer && mlst_q) begin
            mvld_d  = 1'b0;
            mlst_d  = 1'b0;
            done_d  = 1'b1;
            rptr_d  = '0;
            rcnt_d  = '0;
            state_d = S_IDLE;
          end else if ((!mvld_q || xfer) && rcnt_q != len_q) begin
            mdat_d = mem[rptr_q];
            mvld_d = 1'b1;
            mlst_d = (rcnt_q + ONE == len_q);
            rptr_d = rptr_q + AW'(1);
            rcnt_d = rcnt_q + ONE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= s_data;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= S_IDLE;
      thr_q   <= '0;
      len_q   <= LEN_MAX;
      prev_q  <= '0;
      pvld_q  <= 1'b0;
      wptr_q  <= '0;
      wcnt_q  <= '0;
      rptr_q  <= '0;
      rcnt_q  <= '0;
      mdat_q  <= '0;
      mvld_q  <= 1'b0;
      mlst_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      thr_q   <= thr_d;
      len_q   <= len_d;
      prev_q  <= prev_d;
      pvld_q  <= pvld_d;
      wptr_q  <= wptr_d;
      wcnt_q  <= wcnt_d;
      rptr_q  <= rptr_d;
      rcnt_q  <= rcnt_d;
      mdat_q  <= mdat_d;
      mvld_q  <= mvld_d;
      mlst_q  <= mlst_d;
      done_q  <= done_d;
    end
  end

  assign m_data  = mdat_q;
  assign m_valid = mvld_q;
  assign m_last  = mlst_q;
  assign state   = state_q;
  assign done    = done_q;

endmodule

// File: tb/tb_adc_capture.sv
// Randomized bench for adc_capture; expected readout comes from a
// trigger-search model over the driven sample list.
module tb_adc_capture;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [13:0] s_data;
  logic        s_valid;
  logic        arm;
  logic        abort;
  logic [13:0] thresh;
  logic [8:0]  cap_len;
  logic [13:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic [1:0]  state;
  logic        done;

  int checks = 0;
  int errors = 0;

  adc_capture #(.DW(14), .DEPTH(256), .LW(9)) dut (
    .clk     (clk),
    .aresetn (aresetn),
    .s_data  (s_data),
    .s_valid (s_valid),
    .arm     (arm),
    .abort   (abort),
    .thresh  (thresh),
    .cap_len (cap_len),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_last  (m_last),
    .state   (state),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_capture(input logic [13:0] thr, input int len_in,
                            input logic [13:0] smp[$], input bit gaps,
                            output logic [13:0] exq[$]);
    int le;
    int t;
    le = (len_in == 0 || len_in > 256) ? 256 : len_in;
    t = -1;
    for (int i = 1; i < smp.size(); i++)
      if (t < 0 && smp[i-1] < thr && smp[i] >= thr) t = i;
    exq = {};
    for (int i = 0; i < le; i++) exq.push_back(smp[t+i]);
    thresh = thr;
    cap_len = 9'(len_in);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    thresh = 14'($urandom);
    cap_len = 9'($urandom);
    chk("armed", 32'(state), 32'd1);
    for (int i = 0; i <= t + le - 1; i++) begin
      if (gaps)
        while ($urandom_range(2) == 0) begin
          s_valid = 1'b0;
          s_data = 14'($urandom);
          arm = 1'($urandom);
          thresh = 14'($urandom);
          cap_len = 9'($urandom);
          tick();
        end
      arm = 1'b0;
      s_valid = 1'b1;
      s_data = smp[i];
      tick();
      if (i == t && le > 1) chk("capture", 32'(state), 32'd2);
    end
    s_valid = 1'b0;
    chk("rd_entry", 32'(state), 32'd3);
  endtask

  task automatic do_readout(input logic [13:0] exq[$], input int mode);
    int n = 0;
    int cyc = 0;
    int first = -1;
    bit hold = 0;
    bit fin = 0;
    logic [13:0] hd = '0;
    logic hl = 1'b0;
    while (!fin && cyc < 4 * exq.size() + 20) begin
      case (mode)
        0: m_ready = 1'b1;
        1: m_ready = (cyc % 2 == 0);
        default: m_ready = 1'($urandom);
      endcase
      s_valid = 1'($urandom);
      s_data = 14'($urandom);
      if (hold) begin
        chk("stall_valid", 32'(m_valid), 32'd1);
        chk("stall_data", 32'(m_data), 32'(hd));
        chk("stall_last", 32'(m_last), 32'(hl));
      end
      hold = 0;
      if (m_valid && first < 0) first = cyc;
      if (m_valid && m_ready) begin
        chk("rd_data", 32'(m_data), 32'(exq[n]));
        chk("rd_last", 32'(m_last), 32'(n == exq.size() - 1));
        n++;
        if (n == exq.size()) fin = 1;
      end else if (m_valid) begin
        hold = 1;
        hd = m_data;
        hl = m_last;
      end
      tick();
      cyc++;
    end
    s_valid = 1'b0;
    m_ready = 1'b0;
    chk("mv_latency", 32'(first >= 0 && first <= 2), 32'd1);
    if (!fin) begin
      chk("rd_timeout", 32'd0, 32'd1);
    end else begin
      chk("done", 32'(done), 32'd1);
      chk("st_idle", 32'(state), 32'd0);
      chk("mv_drop", 32'(m_valid), 32'd0);
      tick();
      chk("done_pulse", 32'(done), 32'd0);
    end
  endtask

  logic [13:0] smp[$];
  logic [13:0] exq[$];
  logic [13:0] sine[] = '{14'h2000, 14'h2322, 14'h263D, 14'h2949,
                          14'h2C3E, 14'h2F15, 14'h31C6, 14'h344C,
                          14'h369F, 14'h38BB, 14'h3A8D, 14'h3C11};

  initial begin
    int bad;
    aresetn = 1'b0;
    s_data = '0;
    s_valid = 1'b0;
    arm = 1'b0;
    abort = 1'b0;
    thresh = '0;
    cap_len = '0;
    m_ready = 1'b0;
    tick();
    tick();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_mvalid", 32'(m_valid), 32'd0);
    chk("rst_mlast", 32'(m_last), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_mdata", 32'(m_data), 32'd0);
    aresetn = 1'b1;
    tick();

    smp = {};
    foreach (sine[i]) smp.push_back(sine[i]);
    do_capture(14'h3000, 4, smp, 0, exq);
    do_readout(exq, 0);
    do_capture(14'h3000, 4, smp, 0, exq);
    do_readout(exq, 1);

    smp = '{14'h2000, 14'h2100, 14'h1CDD, 14'h2000, 14'h2222, 14'h2444};
    do_capture(14'h2000, 3, smp, 0, exq);
    do_readout(exq, 0);

    smp = {};
    for (int i = 0; i < 280; i++) smp.push_back(14'(14'h0FF0 + i));
    do_capture(14'h1000, 0, smp, 1, exq);
    do_readout(exq, 2);

    smp = '{14'h0100, 14'h0200, 14'h3000, 14'h3100};
    do_capture(14'h1000, 1, smp, 0, exq);
    do_readout(exq, 0);

    thresh = 14'h1000;
    cap_len = 9'd8;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    s_valid = 1'b1;
    s_data = 14'h0800;
    tick();
    s_data = 14'h1800;
    tick();
    chk("ab_capture", 32'(state), 32'd2);
    s_data = 14'h1900;
    tick();
    s_valid = 1'b0;
    abort = 1'b1;
    m_ready = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_idle", 32'(state), 32'd0);
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      s_valid = 1'($urandom);
      s_data = 14'($urandom);
      if (m_valid || done || state != 2'd0) bad++;
      tick();
    end
    s_valid = 1'b0;
    m_ready = 1'b0;
    chk("ab_quiet", 32'(bad), 32'd0);
    smp = '{14'h0500, 14'h0700, 14'h1200, 14'h1300, 14'h0100, 14'h1400};
    do_capture(14'h1000, 4, smp, 0, exq);
    do_readout(exq, 0);

    smp = '{14'h0010, 14'h0900, 14'h0A00, 14'h0B00, 14'h0C00};
    do_capture(14'h0800, 3, smp, 0, exq);
    m_ready = 1'b0;
    tick();
    tick();
    chk("rs_mvalid_hi", 32'(m_valid), 32'd1);
    #2;
    aresetn = 1'b0;
    #1;
    chk("rs_mvalid", 32'(m_valid), 32'd0);
    chk("rs_mlast", 32'(m_last), 32'd0);
    chk("rs_done", 32'(done), 32'd0);
    chk("rs_state", 32'(state), 32'd0);
    tick();
    aresetn = 1'b1;
    tick();
    chk("rs_wait_arm", 32'(state), 32'd0);
    do_capture(14'h0800, 3, smp, 0, exq);
    do_readout(exq, 1);

    for (int r = 0; r < 6; r++) begin
      logic [13:0] thr;
      int len;
      int n0;
      thr = 14'($urandom_range(14'h3000, 14'h1000));
      len = $urandom_range(20, 1);
      n0 = $urandom_range(12, 1);
      smp = {};
      for (int i = 0; i < n0; i++) smp.push_back(14'($urandom));
      smp.push_back(thr - 14'd1);
      smp.push_back(thr + 14'($urandom_range(255)));
      for (int i = 0; i < len + 5; i++) smp.push_back(14'($urandom));
      do_capture(thr, len, smp, 1, exq);
      do_readout(exq, 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_capture.md
ADC_CAPTURE -- requirements
Module: adc_capture

Interface
REQ-001 Parameter DW, default 14, sample width in bits (offset binary, midscale 0x2000).
REQ-002 Parameter DEPTH, default 256, capture buffer depth; SHALL be a power of 2, at least 4.
REQ-003 Parameter LW, default 9, width of cap_len; equals log2(DEPTH)+1.
REQ-004 clk  in  1  single clock for all logic; samples arrive in this domain from the ADC deserializer.
REQ-005 aresetn  in  1  reset, asynchronous and active-low.
REQ-006 s_data  in  DW  deserialized ADC sample.
REQ-007 s_valid  in  1  s_data valid this cycle; no backpressure.
REQ-008 arm  in  1  single-cycle start pulse.
REQ-009 abort  in  1  single-cycle cancel pulse.
REQ-010 thresh  in  DW  trigger level, unsigned compare.
REQ-011 cap_len  in  LW  number of samples to capture.
REQ-012 m_data  out  DW  readout sample.
REQ-013 m_valid  out  1  readout valid.
REQ-014 m_ready  in  1  readout accept.
REQ-015 m_last  out  1  marks final readout sample.
REQ-016 state  out  2  IDLE=0, ARMED=1, CAPTURE=2, READOUT=3.
REQ-017 done  out  1  one-cycle pulse after final sample accepted.

Function
REQ-018 IDLE: arm SHALL latch thresh and cap_len and move to ARMED next cycle; cap_len 0 or greater than DEPTH SHALL be clamped to DEPTH.
REQ-019 arm outside IDLE SHALL be ignored; latched thresh/len SHALL not change until the next accepted arm.
REQ-020 ARMED: block SHALL hold the previous valid sample; the first valid sample after arm only loads it and cannot trigger.
REQ-021 Trigger SHALL occur on a valid sample with prev < thresh and s_data >= thresh; invalid cycles do not update prev.
REQ-022 Triggering sample SHALL be written to buffer address 0 in the trigger cycle; state goes to CAPTURE, or directly to READOUT when len is 1.
REQ-023 CAPTURE: each valid sample SHALL be written at the next address; cycles without s_valid are skipped; after len samples are stored, state goes to READOUT.
REQ-024 READOUT: m_valid SHALL assert within 2 cycles of entry, presenting samples in capture order starting at address 0.
REQ-025 A transfer occurs on m_valid and m_ready; m_data and m_last SHALL stay stable while m_valid is high and m_ready low; back-to-back transfers SHALL sustain one per cycle.
REQ-026 m_last SHALL be high only with the len-th sample; on its transfer the block SHALL drop m_valid, pulse done for 1 cycle, and return to IDLE.
REQ-027 s_valid during READOUT/IDLE SHALL be ignored; buffer contents SHALL not be overwritten.
REQ-028 abort in any state SHALL return to IDLE next cycle, drop m_valid, clear pointers, and not pulse done; abort takes priority over arm, trigger and transfer in the same cycle.
REQ-029 Address counters SHALL be log2(DEPTH) bits plus a count of LW bits; capture of DEPTH samples SHALL not wrap or overwrite address 0.

Reset
REQ-030 While aresetn is low: state=IDLE, m_valid=0, m_last=0, done=0, m_data=0, pointers/counters/prev cleared, latched len=DEPTH, thresh=0; buffer RAM is not reset.
REQ-031 Reset assertion mid-capture or mid-readout SHALL take effect immediately with no further writes or transfers; after release the block SHALL wait for a new arm.

Verification
REQ-032 thresh=0x3000, len=4, arm, then 14-bit sine ramp 0x2000,0x2322,0x263D,0x2949,0x2C3E,0x2F15,0x31C6,... with m_ready=1 -> readout 0x31C6,0x344C,0x369F,0x38BB, m_last on 4th, done one cycle after.
REQ-033 Same stimulus, m_ready toggling 1-0-1-0 -> identical sequence, data held stable during stalls, no sample dropped or repeated.
REQ-034 thresh=0x2000, first valid sample after arm = 0x2000 -> no trigger on it; trigger only at next upward crossing (0x1CDD then 0x2000 gives trigger on 0x2000).
REQ-035 len=0, input constantly rising past thresh -> exactly 256 samples read out, last with m_last; len=1 -> single sample with m_last, state ARMED->READOUT directly.
REQ-036 abort asserted during CAPTURE after 2 samples -> state IDLE next cycle, m_valid never asserts, done stays 0; subsequent arm/trigger captures normally.
REQ-037 aresetn low during READOUT with m_valid high -> m_valid, m_last, done, state all 0 immediately; arm after release restarts capture.
